// File: rtl/eq_biquad_sequencer_if.sv
// Sequencer bus: sample handshake, band-0 history, band starts, output handshake and coefficient config.
// Defining EQ_SEQ_BYPASS_EN adds the bypass request signal.
interface eq_biquad_sequencer_if #(
  parameter int N_BANDS = 4
);
  localparam int AW = $clog2(N_BANDS) + 3;

  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_data;
  logic [31:0]            x0;
  logic [31:0]            x1;
  logic [31:0]            x2;
  logic [N_BANDS-1:0]     start;
  logic [31:0]            last_y0;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic                   cfg_we;
  logic [AW-1:0]          cfg_addr;
  logic [31:0]            cfg_data;
  logic                   cfg_commit;
  logic [N_BANDS*160-1:0] coef;
`ifdef EQ_SEQ_BYPASS_EN
  logic                   bypass;
`endif

  modport slave (
    input  in_valid, in_data, last_y0, out_ready, cfg_we, cfg_addr, cfg_data, cfg_commit,
`ifdef EQ_SEQ_BYPASS_EN
    input  bypass,
`endif
    output in_ready, x0, x1, x2, start, out_valid, out_data, coef
  );

  modport master (
    output in_valid, in_data, last_y0, out_ready, cfg_we, cfg_addr, cfg_data, cfg_commit,
`ifdef EQ_SEQ_BYPASS_EN
    output bypass,
`endif
    input  in_ready, x0, x1, x2, start, out_valid, out_data, coef
  );
endinterface

// File: rtl/eq_biquad_sequencer.sv
// Sequences a cascade of biquad stages per sample and owns the double-buffered coefficient banks.
// Defining EQ_SEQ_BYPASS_EN lets an accept with bypass set skip the cascade entirely.
module eq_biquad_sequencer #(
  parameter int N_BANDS    = 4,
  parameter int SETTLE_CYC = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  eq_biquad_sequencer_if.slave bus
);
  localparam int BW     = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam int CW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int BANK_W = 160;
  localparam int COEF_W = 32;
  localparam logic [159:0]       PASS_BAND = {128'h0, 32'h3F80_0000};
  localparam logic [CW-1:0]      CNT_LOAD  = CW'(SETTLE_CYC - 1);
  localparam logic [BW-1:0]      BAND_LAST = BW'(N_BANDS - 1);
  localparam logic [N_BANDS-1:0] START_ONE = N_BANDS'(1'b1);

  typedef enum logic [2:0] {IDLE, SETTLE, FIRE, CAPTURE, OUT} state_t;

  state_t                 state_r;
  logic [BW-1:0]          band_r;
  logic [CW-1:0]          cnt_r;
  logic [31:0]            x0_r;
  logic [31:0]            x1_r;
  logic [31:0]            x2_r;
  logic [31:0]            out_data_r;
  logic                   out_valid_r;
  logic                   in_ready_r;
  logic                   pending_r;
  logic [N_BANDS-1:0]     start_r;
  logic [N_BANDS*160-1:0] shadow_r;
  logic [N_BANDS*160-1:0] active_r;
  logic                   accept_s;
  logic                   copy_s;
  logic                   bypass_s;
  logic                   wr_ok_s;
  logic [31:0]            wr_band_s;
  logic [2:0]             wr_idx_s;

`ifdef EQ_SEQ_BYPASS_EN
  assign bypass_s = bus.bypass;
`else
  assign bypass_s = 1'b0;
`endif

  // Accept and bank-copy qualifiers; both are only honoured while idle.
  always_comb begin
    accept_s = (state_r == IDLE) && bus.in_valid;
    copy_s   = (state_r == IDLE) && (pending_r || bus.cfg_commit);
  end

  // Decode the shadow write address, dropping out-of-range bands and indices.
  always_comb begin
    wr_band_s = 32'(bus.cfg_addr) >> 3'd3;
    wr_idx_s  = bus.cfg_addr[2:0];
    if (bus.cfg_we && (wr_idx_s <= 3'd4) && (wr_band_s < 32'(N_BANDS))) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Sample sequencing FSM with registered handshake, history, start pulses and output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= IDLE;
      band_r      <= '0;
      cnt_r       <= '0;
      x0_r        <= '0;
      x1_r        <= '0;
      x2_r        <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      start_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && bypass_s) begin
            out_data_r  <= bus.in_data;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b0;
            state_r     <= OUT;
          end else if (accept_s) begin
            x2_r       <= x1_r;
            x1_r       <= x0_r;
            x0_r       <= bus.in_data;
            band_r     <= '0;
            cnt_r      <= CNT_LOAD;
            in_ready_r <= 1'b0;
            state_r    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_r == '0) begin
            start_r <= START_ONE << band_r;
            state_r <= FIRE;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        FIRE: begin
          start_r <= '0;
          if (band_r == BAND_LAST) begin
            state_r <= CAPTURE;
          end else begin
            band_r  <= band_r + 1'b1;
            cnt_r   <= CNT_LOAD;
            state_r <= SETTLE;
          end
        end
        CAPTURE: begin
          out_data_r  <= bus.last_y0;
          out_valid_r <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          start_r     <= '0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  // Coefficient banks: the copy reads the shadow before a same-edge write lands in it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_r  <= {N_BANDS{PASS_BAND}};
      active_r  <= {N_BANDS{PASS_BAND}};
      pending_r <= 1'b0;
    end else begin
      if (copy_s) begin
        active_r <= shadow_r;
      end
      if (wr_ok_s) begin
        shadow_r[int'(wr_band_s)*BANK_W + int'(wr_idx_s)*COEF_W +: COEF_W] <= bus.cfg_data;
      end
      pending_r <= (pending_r || bus.cfg_commit) && !copy_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.x0        = x0_r;
  assign bus.x1        = x1_r;
  assign bus.x2        = x2_r;
  assign bus.start     = start_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.coef      = active_r;
endmodule

// File: tb/tb_eq_biquad_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-count reference model.
`timescale 1ns/1ps
module tb_eq_biquad_sequencer;
  localparam int NB  = 4;
  localparam int SC  = 12;
  localparam int LAT = NB * (SC + 1) + 1;
  localparam logic [159:0] PASS = {128'h0, 32'h3F80_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  eq_biquad_sequencer_if #(.N_BANDS(NB)) bus ();
  eq_biquad_sequencer #(.N_BANDS(NB), .SETTLE_CYC(SC)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiply a float by a positive power-of-two coefficient: add exponents.
  function automatic logic [31:0] scale(input logic [31:0] x, input logic [31:0] b);
    logic [31:0] r;
    r = x;
    r[30:23] = x[30:23] + b[30:23] - 8'd127;
    return r;
  endfunction

  // External stage emulation: each band on its start pulse scales its input by its b0.
  logic [31:0] stage_y [NB];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NB; k++) stage_y[k] <= 32'h0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (bus.start[k]) begin
          if (k == 0) stage_y[k] <= scale(bus.x0, bus.coef[k*160 +: 32]);
          else        stage_y[k] <= scale(stage_y[k-1], bus.coef[k*160 +: 32]);
        end
      end
    end
  end
  assign bus.last_y0 = stage_y[NB-1];

  // Reference model state
  logic [639:0] m_shadow, m_active;
  logic         m_pending, m_busy, m_outv;
  logic [31:0]  m_x0, m_x1, m_x2, m_out, m_exp;
  int           m_n;

  task automatic model_reset;
    m_shadow = {NB{PASS}}; m_active = {NB{PASS}}; m_pending = 1'b0;
    m_busy = 1'b0; m_outv = 1'b0; m_n = 0;
    m_x0 = '0; m_x1 = '0; m_x2 = '0; m_out = '0; m_exp = '0;
  endtask

  initial begin
    logic idle, byp;
    int band, idx;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        idle = !m_busy && !m_outv;
        byp = 1'b0;
`ifdef EQ_SEQ_BYPASS_EN
        byp = bus.bypass;
`endif
        if (idle && (m_pending || bus.cfg_commit)) begin
          m_active = m_shadow;
          m_pending = 1'b0;
        end else if (bus.cfg_commit) begin
          m_pending = 1'b1;
        end
        band = int'(bus.cfg_addr) / 8;
        idx  = int'(bus.cfg_addr) % 8;
        if (bus.cfg_we && idx <= 4 && band < NB) m_shadow[band*160 + idx*32 +: 32] = bus.cfg_data;
        if (m_busy) begin
          m_n++;
          if (m_n == LAT) begin m_busy = 1'b0; m_outv = 1'b1; m_out = m_exp; end
        end else if (m_outv) begin
          if (bus.out_ready) m_outv = 1'b0;
        end else if (bus.in_valid) begin
          if (byp) begin
            m_outv = 1'b1; m_out = bus.in_data;
          end else begin
            m_x2 = m_x1; m_x1 = m_x0; m_x0 = bus.in_data;
            m_exp = bus.in_data;
            for (int k = 0; k < NB; k++) m_exp = scale(m_exp, m_active[k*160 +: 32]);
            m_busy = 1'b1; m_n = 0;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    logic [NB-1:0] exp_start;
    if (!rst) begin
      exp_start = '0;
      if (m_busy && (m_n % (SC + 1)) == SC) exp_start[m_n / (SC + 1)] = 1'b1;
      chk("in_ready", bus.in_ready, !m_busy && !m_outv);
      chk("start", bus.start, exp_start);
      chk("out_valid", bus.out_valid, m_outv);
      chk("out_data", bus.out_data, m_out);
      chk("x0", bus.x0, m_x0);
      chk("x1", bus.x1, m_x1);
      chk("x2", bus.x2, m_x2);
      chk("coef", bus.coef, m_active);
    end
  end

  task automatic send(input logic [31:0] d);
    int g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 4 * LAT) begin @(negedge clk); g++; end
    chk("send_timeout", bus.in_ready, 1'b1);
    #1 bus.in_valid = 1'b1; bus.in_data = d;
    @(negedge clk);
    #1 bus.in_valid = 1'b0; bus.in_data = $urandom;
  endtask

  task automatic wait_valid;
    int g = 0;
    while (!bus.out_valid && g < LAT + 10) begin @(negedge clk); g++; end
    chk("valid_timeout", bus.out_valid, 1'b1);
  endtask

  task automatic release_out;
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic drain(input string name, input logic [31:0] exp);
    wait_valid();
    chk(name, bus.out_data, exp);
    release_out();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
`ifdef EQ_SEQ_BYPASS_EN
    bus.bypass = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_coef", bus.coef, {NB{PASS}});
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_start", bus.start, 4'b0000);

    // T1: 3.0 through passthrough bands, start pulses every 13 cycles
    send(32'h4040_0000);
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      if (n == 12) chk("t1_start_b0", bus.start, 4'b0001);
      if (n == 25) chk("t1_start_b1", bus.start, 4'b0010);
      if (n == 38) chk("t1_start_b2", bus.start, 4'b0100);
      if (n == 51) chk("t1_start_b3", bus.start, 4'b1000);
      if (n == 52) chk("t1_not_yet", bus.out_valid, 1'b0);
      if (n == 53) chk("t1_valid53", bus.out_valid, 1'b1);
    end
    chk("t1_data", bus.out_data, 32'h4040_0000);
    release_out();

    // T2: history after three samples
    send(32'h3F80_0000); drain("t2_s1", 32'h3F80_0000);
    send(32'h4000_0000); drain("t2_s2", 32'h4000_0000);
    send(32'h4080_0000);
    chk("t2_x0", bus.x0, 32'h4080_0000);
    chk("t2_x1", bus.x1, 32'h4000_0000);
    chk("t2_x2", bus.x2, 32'h3F80_0000);
    drain("t2_s3", 32'h4080_0000);

    // T3: band 0 b0 := 0.5 written and committed while busy
    send(32'h3F80_0000);
    #1 bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_data = 32'h3F00_0000;
    @(negedge clk);
    #1 bus.cfg_we = 1'b0; bus.cfg_commit = 1'b1;
    @(negedge clk);
    #1 bus.cfg_commit = 1'b0;
    chk("t3_active_held", bus.coef[31:0], 32'h3F80_0000);
    drain("t3_old_bank", 32'h3F80_0000);
    @(negedge clk);
    chk("t3_active_new", bus.coef[31:0], 32'h3F00_0000);
    send(32'h4000_0000);
    wait_valid();
    chk("t3_new_bank", bus.out_data, 32'h3F80_0000);

    // T4: output held while downstream stalls
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", bus.out_valid, 1'b1);
      chk("t4_hold_data", bus.out_data, 32'h3F80_0000);
      chk("t4_hold_ready", bus.in_ready, 1'b0);
    end
    release_out();
    chk("t4_idle_ready", bus.in_ready, 1'b1);
    chk("t4_idle_valid", bus.out_valid, 1'b0);

`ifdef EQ_SEQ_BYPASS_EN
    // T6: bypass sample straight to output
    #1 bus.bypass = 1'b1;
    send(32'h40A0_0000);
    chk("t6_valid", bus.out_valid, 1'b1);
    chk("t6_data", bus.out_data, 32'h40A0_0000);
    chk("t6_start", bus.start, 4'b0000);
    chk("t6_x0", bus.x0, 32'h4000_0000);
    #1 bus.bypass = 1'b0;
    release_out();
`endif

    // T5: reset during band 1 settle drops the sample
    send(32'h3F80_0000);
    repeat (18) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_start", bus.start, 4'b0000);
    chk("t5_ready", bus.in_ready, 1'b1);
    repeat (LAT + 5) @(negedge clk);
    chk("t5_no_output", bus.out_valid, 1'b0);
    chk("t5_coef_reset", bus.coef, {NB{PASS}});

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      bus.in_valid  = ($urandom % 4) == 0;
      bus.in_data   = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      bus.out_ready = ($urandom % 3) != 0;
      bus.cfg_we    = ($urandom % 5) == 0;
      bus.cfg_addr  = 5'($urandom);
      if (bus.cfg_addr[2:0] == 3'd0) bus.cfg_data = {1'b0, 8'($urandom_range(126, 129)), 23'h0};
      else                           bus.cfg_data = $urandom;
      bus.cfg_commit = ($urandom % 20) == 0;
`ifdef EQ_SEQ_BYPASS_EN
      bus.bypass = ($urandom % 4) == 0;
`endif
    end
    #1 bus.in_valid = 1'b0; bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0; bus.out_ready = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    chk("final_idle", bus.in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
